// File: rtl/weight_access_ctrl.sv
// Weight-store access controller: random-fill sequencing after reset, then
// range-checked block reads/writes of N packed weights with a held store access.
module weight_access_ctrl #(
  parameter int N           = 10,
  parameter int W           = 10,
  parameter int DEPTH       = 65,
  parameter int HOLD        = 4,
  parameter int INIT_CYCLES = 66
) (
  input  logic           Clock,
  input  logic           Rst,
  input  logic           init_req,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [6:0]     req_addr,
  input  logic [N*W-1:0] req_data,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [N*W-1:0] resp_data,
  output logic           resp_err,
  output logic           init_done,
  output logic           mem_In,
  output logic           mem_WE,
  output logic [6:0]     mem_Address,
  output logic [N*W-1:0] mem_D,
  input  logic [N*W-1:0] mem_Q
);

  localparam int CNT_MAX = (INIT_CYCLES > HOLD) ? INIT_CYCLES : HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_in_q;
  logic            mem_we_q;
  logic [6:0]      mem_addr_q;
  logic [N*W-1:0]  mem_d_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [N*W-1:0]  resp_data_q;
  logic            resp_err_q;
  logic            init_done_q;

  // Last address of the block, one bit wider than req_addr so it cannot wrap.
  logic [7:0]      last_addr_d;
  logic            range_err_d;
  logic            accept_d;

  assign last_addr_d = {1'b0, req_addr} + 8'(N - 1);
  assign range_err_d = (last_addr_d > 8'(DEPTH - 1));
  assign accept_d    = req_valid && req_ready_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its peers, independent of order.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      mem_in_q     <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_q       <= '0;
            mem_in_q    <= 1'b0;
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_IDLE: begin
          // A refill request wins over a same-cycle client request.
          if (init_req) begin
            cnt_q       <= '0;
            mem_in_q    <= 1'b1;
            init_done_q <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_INIT;
          end else if (accept_d) begin
            req_ready_q <= 1'b0;
            if (range_err_d) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
              state_q      <= S_RESP;
            end else begin
              mem_addr_q <= req_addr;
              mem_we_q   <= req_write;
              mem_d_q    <= req_data;
              cnt_q      <= '0;
              state_q    <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_data_q  <= mem_we_q ? '0 : mem_Q;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          cnt_q        <= '0;
          mem_in_q     <= 1'b1;
          mem_we_q     <= 1'b0;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          init_done_q  <= 1'b0;
          state_q      <= S_INIT;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign init_done   = init_done_q;
  assign mem_In      = mem_in_q;
  assign mem_WE      = mem_we_q;
  assign mem_Address = mem_addr_q;
  assign mem_D       = mem_d_q;

endmodule

// File: tb/tb_weight_access_ctrl.sv
// Scoreboard bench for weight_access_ctrl with a behavioural weight-store model.
module tb_weight_access_ctrl;

  localparam int N           = 10;
  localparam int W           = 10;
  localparam int DEPTH       = 65;
  localparam int HOLD        = 4;
  localparam int INIT_CYCLES = 66;
  localparam int NW          = N * W;

  typedef struct {
    logic          err;
    logic [NW-1:0] data;
  } resp_t;

  logic          Clock;
  logic          Rst;
  logic          init_req;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [6:0]    req_addr;
  logic [NW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [NW-1:0] resp_data;
  logic          resp_err;
  logic          init_done;
  logic          mem_In;
  logic          mem_WE;
  logic [6:0]    mem_Address;
  logic [NW-1:0] mem_D;
  logic [NW-1:0] mem_Q;

  int tests = 0;
  int fails = 0;

  resp_t      sb_q[$];
  logic [W-1:0] store [DEPTH];
  logic [W-1:0] ref_w [DEPTH];

  weight_access_ctrl #(
    .N(N), .W(W), .DEPTH(DEPTH), .HOLD(HOLD), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .Clock      (Clock),
    .Rst        (Rst),
    .init_req   (init_req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .init_done  (init_done),
    .mem_In     (mem_In),
    .mem_WE     (mem_WE),
    .mem_Address(mem_Address),
    .mem_D      (mem_D),
    .mem_Q      (mem_Q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Store model: random fill while mem_In, block write while mem_WE.
  always @(posedge Clock) begin
    if (mem_In) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= W'($urandom);
    end else if (mem_WE) begin
      for (int i = 0; i < N; i++)
        if (int'(mem_Address) + i < DEPTH) store[int'(mem_Address) + i] <= mem_D[i*W +: W];
    end
  end

  always_comb begin
    mem_Q = '0;
    for (int i = 0; i < N; i++)
      if (int'(mem_Address) + i < DEPTH) mem_Q[i*W +: W] = store[int'(mem_Address) + i];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] pack_ref(input logic [6:0] a);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = ref_w[int'(a) + i];
    return v;
  endfunction

  function automatic logic [NW-1:0] rand_block();
    logic [NW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Counts edges until mem_In drops; also flags any response or write seen meanwhile.
  task automatic count_init(input string tag);
    int  n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (mem_In && n < 200) begin
      @(posedge Clock); #1;
      n++;
      if (resp_valid || mem_WE || (mem_In && (req_ready || init_done))) bad = 1'b1;
    end
    check({tag, "_init_len"}, n, INIT_CYCLES);
    check({tag, "_init_quiet"}, bad, 1'b0);
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_ready"}, req_ready, 1'b1);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [6:0] addr,
                        input logic [NW-1:0] data, input int stall);
    int            guard, lat, we_cycles;
    logic          err, stable, stall_ok;
    resp_t         exp;
    logic [NW-1:0] hold_data;
    logic          hold_err;

    guard = 0;
    while (!req_ready && guard < 200) begin
      @(posedge Clock); #1;
      guard++;
    end
    check({tag, "_ready_wait"}, req_ready, 1'b1);

    err      = (int'(addr) + N - 1 > DEPTH - 1);
    exp.err  = err;
    exp.data = (err || wr) ? '0 : pack_ref(addr);
    if (!err && wr)
      for (int i = 0; i < N; i++) ref_w[int'(addr) + i] = data[i*W +: W];
    sb_q.push_back(exp);

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    @(posedge Clock); #1;
    req_valid = 1'b0;

    lat       = 1;
    we_cycles = 0;
    stable    = 1'b1;
    if (err && mem_WE) stable = 1'b0;
    while (!resp_valid && lat < 50) begin
      if (mem_Address !== addr || mem_D !== data || mem_WE !== wr) stable = 1'b0;
      if (mem_WE) we_cycles++;
      @(posedge Clock); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, err ? 1 : HOLD + 1);
    check({tag, "_mem_hold"}, stable, 1'b1);
    check({tag, "_we_cycles"}, we_cycles, (wr && !err) ? HOLD : 0);
    check({tag, "_we_in_resp"}, mem_WE, 1'b0);

    if (stall > 0) begin
      hold_data = resp_data;
      hold_err  = resp_err;
      stall_ok  = 1'b1;
      for (int k = 0; k < stall; k++) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'd1;
        req_data  = rand_block();
        @(posedge Clock); #1;
        if (!resp_valid || resp_data !== hold_data || resp_err !== hold_err ||
            req_ready || mem_WE) stall_ok = 1'b0;
      end
      req_valid = 1'b0;
      check({tag, "_stall_stable"}, stall_ok, 1'b1);
    end

    resp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 1'b0, 1'b1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_resp_data"}, resp_data, exp.data);
      check({tag, "_resp_err"}, resp_err, exp.err);
    end
    @(posedge Clock); #1;
    resp_ready = 1'b0;
    check({tag, "_resp_drop"}, resp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    logic [NW-1:0] blk;

    Rst        = 1'b0;
    init_req   = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_w[i] = '0;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_mem_In", mem_In, 1'b1);
    check("rst_mem_WE", mem_WE, 1'b0);
    check("rst_mem_Address", mem_Address, 7'd0);
    check("rst_mem_D", mem_D, '0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, '0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_init_done", init_done, 1'b0);

    @(negedge Clock);
    Rst = 1'b1;
    count_init("boot");

    for (int i = 0; i < N; i++) blk[i*W +: W] = W'(i + 1);
    do_req("wr5", 1'b1, 7'd5, blk, 0);
    do_req("rd5", 1'b0, 7'd5, rand_block(), 0);
    check("rd5_weights", resp_data, blk);

    do_req("rd56_err", 1'b0, 7'd56, rand_block(), 0);
    do_req("wr55", 1'b1, 7'd55, rand_block(), 0);
    do_req("rd55_stall", 1'b0, 7'd55, rand_block(), 10);
    do_req("wr0", 1'b1, 7'd0, rand_block(), 0);
    do_req("rd0", 1'b0, 7'd0, rand_block(), 0);
    do_req("wr127_err", 1'b1, 7'd127, rand_block(), 3);

    // Refill request collides with a client request in the same IDLE cycle.
    init_req  = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'd20;
    req_data  = rand_block();
    @(posedge Clock); #1;
    init_req  = 1'b0;
    req_valid = 1'b0;
    check("initreq_mem_In", mem_In, 1'b1);
    check("initreq_ready", req_ready, 1'b0);
    check("initreq_no_we", mem_WE, 1'b0);
    check("initreq_done_low", init_done, 1'b0);
    count_init("initreq");

    do_req("wr30", 1'b1, 7'd30, rand_block(), 0);
    do_req("rd30", 1'b0, 7'd30, rand_block(), 2);

    // Reset in the middle of a write access.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'd10;
    req_data  = rand_block();
    @(posedge Clock); #1;
    req_valid = 1'b0;
    check("midrst_we_before", mem_WE, 1'b1);
    @(posedge Clock); #3;
    Rst = 1'b0;
    #1;
    check("midrst_we", mem_WE, 1'b0);
    check("midrst_mem_In", mem_In, 1'b1);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_ready", req_ready, 1'b0);
    @(negedge Clock);
    Rst = 1'b1;
    count_init("midrst");

    do_req("wr3", 1'b1, 7'd3, rand_block(), 0);
    do_req("rd3", 1'b0, 7'd3, rand_block(), 0);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
